shift_reg_seq_ctrl: RTL

Command sequencer for the 4-bit universal shift register (s1/s0 select, MSB_in/LSB_in serial inputs, I_par parallel load).
- Accepts one command at a time over a valid/ready handshake: load, clear, logical/arithmetic shift or rotate by N.
- Drives the register's select, serial and parallel inputs cycle by cycle, using A_par as feedback for rotate and arithmetic fill.
- Pulses done in the cycle the result is visible on A_par.

---
 rtl/shift_reg_seq_ctrl_pkg.sv | 36 +++
 rtl/shift_count_down.sv | 35 +++
 rtl/shift_reg_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/shift_reg_seq_ctrl_pkg.sv
// ============================================================================
// Module   : shift_reg_seq_ctrl_pkg
// Brief    : Shared op, mode and state encodings for the shift-register
//            command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_reg_seq_ctrl_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_SHL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ASR  = 3'b110;
   localparam logic [2:0] OP_CLR  = 3'b111;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_LOAD  = 2'b01;
   localparam logic [1:0] ST_SHIFT = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   function automatic logic op_is_parallel(input logic [2:0] op);
      return (op == OP_LOAD) || (op == OP_CLR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_count_down.sv
// ============================================================================
// Module   : shift_count_down
// Brief    : Loadable down-counter tracking remaining shifts, with a last flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_count_down #(
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_value,
   output logic             last
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge CLK) begin
      if (!Clear) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_value;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign last = (r_count == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

`default_nettype wire

// File: rtl/shift_reg_seq_ctrl.sv
// ============================================================================
// Module   : shift_reg_seq_ctrl
// Brief    : Command sequencer driving a universal shift register's select,
//            serial and parallel inputs, with A_par feedback.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_seq_ctrl
   import shift_reg_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   input  logic [WIDTH-1:0] A_par,
   output logic             s1,
   output logic             s0,
   output logic             MSB_in,
   output logic             LSB_in,
   output logic [WIDTH-1:0] I_par,
   output logic             busy,
   output logic             done
);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic             r_fill;
   logic             w_accept;
   logic             w_last;
   logic [1:0]       w_mode;
   logic             w_msb;
   logic             w_lsb;
   logic [WIDTH-1:0] w_ipar;

   assign cmd_ready = (r_state == ST_IDLE) & Clear;
   assign w_accept  = cmd_valid & cmd_ready;

   always_ff @(posedge CLK) begin
      if (!Clear) begin
         r_state <= ST_IDLE;
         r_op    <= OP_NOP;
         r_data  <= '0;
         r_fill  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_fill <= cmd_fill;
         end
      end
   end

   shift_count_down #(
      .CNT_W (CNT_W)
   ) u_count (
      .CLK        (CLK),
      .Clear      (Clear),
      .load       (w_accept),
      .dec        (r_state == ST_SHIFT),
      .load_value (cmd_count),
      .last       (w_last)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (op_is_parallel(cmd_op)) begin
                  w_next_state = ST_LOAD;
               end else if ((cmd_op == OP_NOP) || (cmd_count == '0)) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_SHIFT;
               end
            end
         end
         ST_LOAD:  w_next_state = ST_DONE;
         ST_SHIFT: if (w_last) w_next_state = ST_DONE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Serial feedback taps A_par combinationally so rotates see the current value.
   always_comb begin
      w_mode = MODE_HOLD;
      w_msb  = 1'b0;
      w_lsb  = 1'b0;
      w_ipar = '0;
      case (r_state)
         ST_LOAD: begin
            w_mode = MODE_LOAD;
            w_ipar = (r_op == OP_CLR) ? '0 : r_data;
         end
         ST_SHIFT: begin
            case (r_op)
               OP_SHR: begin w_mode = MODE_SHR; w_msb = r_fill;          end
               OP_ASR: begin w_mode = MODE_SHR; w_msb = A_par[WIDTH-1];  end
               OP_ROR: begin w_mode = MODE_SHR; w_msb = A_par[0];        end
               OP_SHL: begin w_mode = MODE_SHL; w_lsb = r_fill;          end
               OP_ROL: begin w_mode = MODE_SHL; w_lsb = A_par[WIDTH-1];  end
               default: w_mode = MODE_HOLD;
            endcase
         end
         default: w_mode = MODE_HOLD;
      endcase
   end

   // Clear masks every output so the register holds on the reset edge itself.
   assign s1     = Clear & w_mode[1];
   assign s0     = Clear & w_mode[0];
   assign MSB_in = Clear & w_msb;
   assign LSB_in = Clear & w_lsb;
   assign I_par  = Clear ? w_ipar : '0;
   assign busy   = Clear & (r_state != ST_IDLE);
   assign done   = Clear & (r_state == ST_DONE);

endmodule

`default_nettype wire
